// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared FSM state type and default widths for the counter sequencer.
package counter_seq_pkg;

    localparam int unsigned DEF_STOP_WIDTH = 3;
    localparam int unsigned DEF_CYC_WIDTH  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRun,
        StResp
    } seq_state_t;

endpackage

// File: rtl/counter_seq_timer.sv
// counter_seq_timer: saturating cycle counter used to measure the RUN phase.
// 'clear' wins over 'enable'; the count stops at all-ones and never wraps.
module counter_seq_timer
    import counter_seq_pkg::*;
#(
    parameter int unsigned CYC_WIDTH = DEF_CYC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CYC_WIDTH-1:0] value,
    output logic                 at_limit
);

    logic [CYC_WIDTH-1:0] value_q, value_d;

    // Next count: clear first, otherwise increment until the limit is reached.
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (enable && !at_limit) begin
            value_d = value_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value    = value_q;
    assign at_limit = &value_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: holds the counter in reset, releases it, and measures the
// cycles until 'ctr_done'. Result (or timeout) goes out on a valid/ready channel.
// Optional trace/check logic is compiled in when COUNTER_SEQ_TRACE_EN is defined.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned STOP_WIDTH = DEF_STOP_WIDTH,
    parameter int unsigned CYC_WIDTH  = DEF_CYC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [STOP_WIDTH-1:0] cmd_stop,
    output logic                  ctr_reset_l,
    output logic [STOP_WIDTH-1:0] ctr_stop,
    input  logic                  ctr_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CYC_WIDTH-1:0]  rsp_cycles,
    output logic                  rsp_timeout
);

    if (CYC_WIDTH <= STOP_WIDTH) begin : g_width_check
        $error("counter_sequencer: CYC_WIDTH must be greater than STOP_WIDTH");
    end

    seq_state_t            state_q, state_d;
    logic                  live_q;
    logic                  ctr_reset_l_q;
    logic [STOP_WIDTH-1:0] ctr_stop_q;
    logic [CYC_WIDTH-1:0]  rsp_cycles_q;
    logic                  rsp_timeout_q;
    logic                  cmd_fire, rsp_fire;
    logic                  tmr_clear, tmr_enable, tmr_at_limit;
    logic [CYC_WIDTH-1:0]  tmr_value;

    counter_seq_timer #(
        .CYC_WIDTH(CYC_WIDTH)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .value   (tmr_value),
        .at_limit(tmr_at_limit)
    );

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done beats timeout when both occur in the same RUN cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_fire) state_d = StArm;
            StArm:  state_d = StRun;
            StRun:  if (ctr_done || tmr_at_limit) state_d = StResp;
            StResp: if (rsp_fire) state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready  = live_q;
            StArm:  tmr_clear  = 1'b1;
            StRun:  tmr_enable = !ctr_done;
            StResp: rsp_valid  = 1'b1;
        endcase
    end

    // Keeps cmd_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Registered counter controls and captured response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_reset_l_q <= 1'b0;
            ctr_stop_q    <= '0;
            rsp_cycles_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // Counter runs only while the FSM is in RUN.
            ctr_reset_l_q <= (state_d == StRun);
            if (cmd_fire) begin
                ctr_stop_q <= cmd_stop;
            end
            if (state_q == StRun && state_d == StResp) begin
                rsp_cycles_q  <= ctr_done ? tmr_value : '1;
                rsp_timeout_q <= !ctr_done;
            end
        end
    end

    assign ctr_reset_l = ctr_reset_l_q;
    assign ctr_stop    = ctr_stop_q;
    assign rsp_cycles  = rsp_cycles_q;
    assign rsp_timeout = rsp_timeout_q;

`ifdef COUNTER_SEQ_TRACE_EN
    // Simulation trace of accepts and responses, with a check of the measured count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (cmd_fire) begin
                $display("sequencer: stop=%0d", cmd_stop);
            end
            if (rsp_fire) begin
                $display("sequencer: cycles=%0d timeout=%0d", rsp_cycles_q, rsp_timeout_q);
                if (!rsp_timeout_q && rsp_cycles_q != CYC_WIDTH'(ctr_stop_q)) begin
                    $error("sequencer: cycles=%0d does not match stop=%0d",
                           rsp_cycles_q, ctr_stop_q);
                end
            end
        end
    end
`else
    // Default build: no trace or check logic.
`endif

endmodule
